axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning AXI address width (bit 10 = slave select).
REQ-002 SHALL have parameter DATA_W, default 32, meaning AXI data width.
REQ-003 SHALL have port aCLK  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port ARESETn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester transaction request.
REQ-006 SHALL have port req_write  in  2  per-requester direction (1 = write, 0 = read).
REQ-007 SHALL have port req_addr  in  2xADDR_W  per-requester address.
REQ-008 SHALL have port req_wdata  in  2xDATA_W  per-requester write data.
REQ-009 SHALL have port req_ready  out  2  request accepted (one-hot or zero).
REQ-010 SHALL have port rsp_valid  out  2  one-cycle completion pulse to granted requester.
REQ-011 SHALL have port rsp_rdata  out  DATA_W  read data (valid with rsp_valid).
REQ-012 SHALL have port rsp_resp  out  2  BRESP/RRESP of completed transaction.
REQ-013 SHALL have AXI-Lite master ports AWADDR/AWVALID/AWREADY, WDATA/WSTRB(4)/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY, standard directions.

Function
REQ-014 SHALL run one transaction at a time; FSM states IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
REQ-015 In IDLE, SHALL assert req_ready[g] combinationally for granted requester g; handshake req_valid[g]&req_ready[g] latches write/addr/wdata and g.
REQ-016 Grant SHALL be round-robin: single requester wins; both requesting -> the one not granted last; pointer reset favours requester 0.
REQ-017 On accepted write SHALL go to WR_AW_W; AWVALID and WVALID SHALL rise together the next cycle, registered.
REQ-018 In WR_AW_W each VALID SHALL stay high with stable ADDR/DATA until its own READY, then drop next cycle independently; same-cycle AWREADY&WREADY SHALL complete both.
REQ-019 When both AW and W done SHALL enter WR_B with BREADY=1; on BVALID capture BRESP, go RSP.
REQ-020 On accepted read SHALL go RD_AR with ARVALID=1 until ARREADY, then RD_R with RREADY=1; on RVALID capture RDATA/RRESP, go RSP.
REQ-021 BREADY SHALL be high only in WR_B; RREADY only in RD_R.
REQ-022 In RSP SHALL pulse rsp_valid[g] one cycle with captured rsp_resp/rsp_rdata, update RR pointer to g, return IDLE; no req_ready in RSP.
REQ-023 rsp_rdata SHALL hold last read data; writes SHALL leave it unchanged.
REQ-024 WSTRB SHALL be constant 4'hF.
REQ-025 Minimum latency: request accept to rsp_valid = 4 cycles (write, all READYs/BVALID already high), 4 cycles (read).
REQ-026 Requests arriving outside IDLE SHALL wait; req_valid dropped before accept SHALL not be serviced.

Reset
REQ-027 ARESETn=0 at an edge SHALL force IDLE, RR pointer to 0, all VALID/READY/req_ready/rsp_valid low, AWADDR/ARADDR/WDATA/rsp_rdata/rsp_resp to 0.
REQ-028 Reset mid-transaction SHALL abandon it with no rsp_valid pulse.

Structure
REQ-029 Shared package SHALL hold the FSM state enum typedef and AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-030 Grant logic SHALL be a sub-module rr_arbiter2 (req[1:0], last pointer in -> one-hot grant out).

Verification
REQ-031 Single write req0 addr 11'h005 data 32'hDEADBEEF, slave READYs always high, BRESP=OKAY -> AWADDR/WDATA match, rsp_valid[0] 4 cycles after accept, rsp_resp=00.
REQ-032 Read req1 addr 11'h40A, ARREADY delayed 3 cycles, RDATA 32'h12345678 RRESP=SLVERR -> ARVALID held 4 cycles stable, rsp_valid[1], rsp_rdata=32'h12345678, rsp_resp=10.
REQ-033 Both requesters valid continuously, 4 transactions -> grants 0,1,0,1.
REQ-034 Write with WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID held, single B accepted, one rsp pulse.
REQ-035 ARESETn low during RD_R -> RREADY low next cycle, no rsp_valid, next request granted to requester 0.

Source files
------------

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI-Lite arbiter.
// Holds the sequencing FSM encoding and the AXI response codes.
package axi_lite_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [3:0] WSTRB_ALL = 4'hF;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. last is the one-hot grant of the previous
// completed transaction; 2'b00 (nothing granted yet) favours requester 0.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == 2'b01) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-Lite master port between two requesters, one transaction
// at a time, with round-robin grant and a one-cycle completion pulse.
//
// state   | meaning
// IDLE    | offer req_ready to the granted requester, latch on handshake
// WR_AW_W | AWVALID/WVALID outstanding, each drops on its own READY
// WR_B    | BREADY high, waiting for the write response
// RD_AR   | ARVALID outstanding until ARREADY
// RD_R    | RREADY high, waiting for read data
// RSP     | rsp_valid pulse to the owner, round-robin pointer update
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                   aCLK,
  input  logic                   ARESETn,

  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [1:0]             rsp_resp,

  output logic [ADDR_W-1:0]      AWADDR,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [DATA_W-1:0]      WDATA,
  output logic [3:0]             WSTRB,
  output logic                   WVALID,
  input  logic                   WREADY,
  input  logic [1:0]             BRESP,
  input  logic                   BVALID,
  output logic                   BREADY,
  output logic [ADDR_W-1:0]      ARADDR,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  input  logic [DATA_W-1:0]      RDATA,
  input  logic [1:0]             RRESP,
  input  logic                   RVALID,
  output logic                   RREADY
);

  arb_state_e state_q, state_d;

  logic [1:0] rr_last_q;
  logic       gnt_idx_q;
  logic [1:0] grant;
  logic       accept;
  logic       accept_idx;
  logic       sel_write;
  logic       aw_ok;
  logic       w_ok;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .last  (rr_last_q),
    .grant (grant)
  );

  // Gated by ARESETn so nothing looks accepted while reset is being applied.
  assign req_ready  = (state_q == IDLE && ARESETn) ? grant : 2'b00;
  assign accept     = |(req_valid & req_ready);
  assign accept_idx = req_ready[1];
  assign sel_write  = req_write[accept_idx];

  // A channel is finished once its VALID has dropped or is being taken now.
  assign aw_ok = !AWVALID || AWREADY;
  assign w_ok  = !WVALID  || WREADY;

  always_ff @(posedge aCLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = sel_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        if (aw_ok && w_ok) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        if (BVALID) begin
          state_d = RSP;
        end
      end
      RD_AR: begin
        if (ARREADY) begin
          state_d = RD_R;
        end
      end
      RD_R: begin
        if (RVALID) begin
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and AXI address/data channel drive.
  always_ff @(posedge aCLK) begin
    if (!ARESETn) begin
      gnt_idx_q <= 1'b0;
      AWADDR    <= '0;
      WDATA     <= '0;
      ARADDR    <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      ARVALID   <= 1'b0;
    end else begin
      if (state_q == IDLE && accept) begin
        gnt_idx_q <= accept_idx;
        if (sel_write) begin
          AWADDR  <= req_addr[accept_idx];
          WDATA   <= req_wdata[accept_idx];
          AWVALID <= 1'b1;
          WVALID  <= 1'b1;
        end else begin
          ARADDR  <= req_addr[accept_idx];
          ARVALID <= 1'b1;
        end
      end
      if (AWVALID && AWREADY) begin
        AWVALID <= 1'b0;
      end
      if (WVALID && WREADY) begin
        WVALID <= 1'b0;
      end
      if (ARVALID && ARREADY) begin
        ARVALID <= 1'b0;
      end
    end
  end

  // Response capture; rsp_rdata only ever changes on a read completion.
  always_ff @(posedge aCLK) begin
    if (!ARESETn) begin
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
      rr_last_q <= 2'b00;
    end else begin
      if (state_q == WR_B && BVALID) begin
        rsp_resp <= BRESP;
      end
      if (state_q == RD_R && RVALID) begin
        rsp_rdata <= RDATA;
        rsp_resp  <= RRESP;
      end
      if (state_q == RSP) begin
        rr_last_q <= onehot2(gnt_idx_q);
      end
    end
  end

  assign BREADY    = (state_q == WR_B);
  assign RREADY    = (state_q == RD_R);
  assign WSTRB     = WSTRB_ALL;
  assign rsp_valid = (state_q == RSP) ? onehot2(gnt_idx_q) : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_axi_lite_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic                   aCLK;
  logic                   ARESETn;
  logic [1:0]             req_valid;
  logic [1:0]             req_write;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_ready;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [1:0]             rsp_resp;
  logic [ADDR_W-1:0]      AWADDR;
  logic                   AWVALID;
  logic                   AWREADY;
  logic [DATA_W-1:0]      WDATA;
  logic [3:0]             WSTRB;
  logic                   WVALID;
  logic                   WREADY;
  logic [1:0]             BRESP;
  logic                   BVALID;
  logic                   BREADY;
  logic [ADDR_W-1:0]      ARADDR;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [DATA_W-1:0]      RDATA;
  logic [1:0]             RRESP;
  logic                   RVALID;
  logic                   RREADY;

  int nerr = 0;
  int nchk = 0;

  axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aCLK      (aCLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .ARADDR    (ARADDR),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RVALID    (RVALID),
    .RREADY    (RREADY)
  );

  initial begin
    aCLK = 1'b0;
    forever #5 aCLK = ~aCLK;
  end

  task automatic cyc();
    @(negedge aCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = 2'b00;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RDATA   = '0;
    RRESP   = 2'b00;
  endtask

  initial begin
    ARESETn   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    slave_idle();

    // Reset state
    cyc(); cyc(); cyc();
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_awvalid",   AWVALID, 0);
    chk("rst_wvalid",    WVALID, 0);
    chk("rst_arvalid",   ARVALID, 0);
    chk("rst_bready",    BREADY, 0);
    chk("rst_rready",    RREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_awaddr",    AWADDR, 0);
    chk("rst_araddr",    ARADDR, 0);
    chk("rst_wdata",     WDATA, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp",  rsp_resp, 2'b00);
    chk("wstrb",         WSTRB, 4'hF);
    req_valid = 2'b00;
    ARESETn   = 1'b1;
    cyc();

    // Single write from requester 0, slave fully ready
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    req_valid    = 2'b01;
    req_write    = 2'b01;
    req_addr[0]  = 11'h005;
    req_wdata[0] = 32'hDEADBEEF;
    #1;
    chk("w1_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    chk("w1_awvalid",   AWVALID, 1);
    chk("w1_wvalid",    WVALID, 1);
    chk("w1_awaddr",    AWADDR, 11'h005);
    chk("w1_wdata",     WDATA, 32'hDEADBEEF);
    chk("w1_no_bready", BREADY, 0);
    chk("w1_rsp_early", rsp_valid, 2'b00);
    cyc();
    chk("w1_bready",    BREADY, 1);
    chk("w1_aw_drop",   AWVALID, 0);
    chk("w1_w_drop",    WVALID, 0);
    chk("w1_rsp_early2", rsp_valid, 2'b00);
    cyc();
    // Fourth cycle counting the accept cycle
    chk("w1_rsp_valid", rsp_valid, 2'b01);
    chk("w1_rsp_resp",  rsp_resp, 2'b00);
    chk("w1_rdata_kept", rsp_rdata, 0);
    chk("w1_rsp_no_ready", req_ready, 2'b00);
    slave_idle();
    cyc();
    chk("w1_rsp_pulse_end", rsp_valid, 2'b00);
    chk("w1_bready_off", BREADY, 0);

    // Read from requester 1, ARREADY held off for three cycles
    req_valid   = 2'b10;
    req_write   = 2'b00;
    req_addr[1] = 11'h40A;
    #1;
    chk("r1_req_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("r1_arvalid_hold", ARVALID, 1);
      chk("r1_araddr_hold",  ARADDR, 11'h40A);
      chk("r1_no_rready",    RREADY, 0);
      if (i < 3) cyc();
    end
    ARREADY = 1'b1;
    cyc();
    ARREADY = 1'b0;
    chk("r1_ar_drop", ARVALID, 0);
    chk("r1_rready",  RREADY, 1);
    RVALID = 1'b1; RDATA = 32'h12345678; RRESP = 2'b10;
    cyc();
    slave_idle();
    chk("r1_rsp_valid", rsp_valid, 2'b10);
    chk("r1_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("r1_rsp_resp",  rsp_resp, 2'b10);
    chk("r1_rready_off", RREADY, 0);
    cyc();
    chk("r1_rsp_pulse_end", rsp_valid, 2'b00);

    // Write with WREADY two cycles ahead of AWREADY
    req_valid    = 2'b01;
    req_write    = 2'b01;
    req_addr[0]  = 11'h123;
    req_wdata[0] = 32'hA5A50001;
    #1;
    chk("w2_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    chk("w2_both_valid", {AWVALID, WVALID}, 2'b11);
    WREADY = 1'b1;
    cyc();
    WREADY = 1'b0;
    chk("w2_w_drop_first", WVALID, 0);
    chk("w2_aw_held",      AWVALID, 1);
    chk("w2_no_bready",    BREADY, 0);
    chk("w2_no_rsp",       rsp_valid, 2'b00);
    cyc();
    chk("w2_aw_held2", AWVALID, 1);
    chk("w2_awaddr",   AWADDR, 11'h123);
    AWREADY = 1'b1;
    cyc();
    AWREADY = 1'b0;
    chk("w2_aw_drop", AWVALID, 0);
    chk("w2_bready",  BREADY, 1);
    chk("w2_no_rsp2", rsp_valid, 2'b00);
    BVALID = 1'b1; BRESP = 2'b01;
    cyc();
    slave_idle();
    chk("w2_rsp_valid", rsp_valid, 2'b01);
    chk("w2_rsp_resp",  rsp_resp, 2'b01);
    chk("w2_rdata_kept", rsp_rdata, 32'h12345678);
    cyc();
    chk("w2_single_pulse", rsp_valid, 2'b00);
    chk("w2_bready_off",   BREADY, 0);

    // Reset while waiting in RD_R; pointer currently favours requester 1
    req_valid   = 2'b10;
    req_write   = 2'b00;
    req_addr[1] = 11'h7FF;
    #1;
    chk("r2_req_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    ARREADY   = 1'b1;
    chk("r2_arvalid", ARVALID, 1);
    cyc();
    ARREADY = 1'b0;
    chk("r2_rready", RREADY, 1);
    ARESETn = 1'b0;
    RVALID  = 1'b1; RDATA = 32'hFFFFFFFF; RRESP = 2'b11;
    cyc();
    chk("r2_rready_reset",  RREADY, 0);
    chk("r2_no_rsp",        rsp_valid, 2'b00);
    chk("r2_rdata_reset",   rsp_rdata, 0);
    chk("r2_resp_reset",    rsp_resp, 2'b00);
    chk("r2_araddr_reset",  ARADDR, 0);
    slave_idle();
    ARESETn = 1'b1;
    cyc();
    chk("r2_no_rsp_after", rsp_valid, 2'b00);

    // Both requesters continuously valid: grants alternate from requester 0
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hCAFE0001; RRESP = 2'b00;
    req_valid    = 2'b11;
    req_write    = 2'b01;
    req_addr[0]  = 11'h011;
    req_addr[1]  = 11'h422;
    req_wdata[0] = 32'h0BADF00D;
    #1;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] exp_g;
      exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
      chk("rr_grant", req_ready, exp_g);
      cyc(); cyc(); cyc();
      chk("rr_rsp_valid", rsp_valid, exp_g);
      chk("rr_rsp_no_ready", req_ready, 2'b00);
      if (t == 1) chk("rr_read_data", rsp_rdata, 32'hCAFE0001);
      cyc();
    end
    chk("rr_grant_next", req_ready, 2'b01);
    chk("rr_last_awaddr", AWADDR, 11'h011);
    chk("rr_last_araddr", ARADDR, 11'h422);

    req_valid = 2'b00;
    slave_idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
